// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between three pipeline requesters
// (bit0 fetch, bit1 operand read, bit2 write stage). A winner is chosen in IDLE,
// holds the RAM for RAM_LAT cycles, then gets a one-cycle garant pulse.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise fixed
// priority bit2 > bit1 > bit0.
//
// state  | meaning
// IDLE   | waiting for a request; req sampled here only
// ACCESS | RAM strobed with the latched winner's access, counter running
// DONE   | one-cycle garant to the winner, read data presented
module ram_arbiter #(
    parameter int DATA_W  = 14,
    parameter int ADDR_W  = 12,
    parameter int RAM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          req,
    input  logic [2:0]          req_we,
    input  logic [3*ADDR_W-1:0] req_addr,
    input  logic [3*DATA_W-1:0] req_wdata,
    output logic [2:0]          garant,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] win_idx;
    logic       win_we;
    logic [1:0] sel;

`ifdef ARB_RR_EN
    // rr_seen distinguishes "nobody served yet" from "index 0 served last", so the
    // first search after reset starts at requester 0.
    logic [1:0] rr_ptr;
    logic       rr_seen;
    logic [1:0] rr_start;
    int         rr_idx;

    // Round-robin pick: first requester found after the last served one.
    always_comb begin
        sel      = 2'd0;
        rr_idx   = 0;
        rr_start = rr_seen ? ((rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1) : 2'd0;
        for (int k = 2; k >= 0; k--) begin
            rr_idx = (int'(rr_start) + k) % 3;
            if (req[rr_idx]) sel = rr_idx[1:0];
        end
    end
`else
    // Fixed priority pick: write stage first, then operand read, then fetch.
    always_comb begin
        sel = 2'd0;
        if (req[2])      sel = 2'd2;
        else if (req[1]) sel = 2'd1;
    end
`endif

    // Arbitration FSM; mem_addr/mem_wdata double as the latched winner fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            win_idx   <= 2'd0;
            win_we    <= 1'b0;
            garant    <= 3'b000;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef ARB_RR_EN
            rr_ptr    <= 2'd0;
            rr_seen   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    garant <= 3'b000;
                    mem_en <= 1'b0;
                    if (|req) begin
                        win_idx   <= sel;
                        win_we    <= req_we[sel];
                        mem_we    <= req_we[sel];
                        mem_addr  <= req_addr[sel*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[sel*DATA_W +: DATA_W];
                        cnt       <= 4'(RAM_LAT);
                        mem_en    <= 1'b1;
                        state     <= ACCESS;
`ifdef ARB_RR_EN
                        rr_ptr    <= sel;
                        rr_seen   <= 1'b1;
`endif
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (!win_we) rdata <= mem_rdata;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        garant <= 3'b001 << win_idx;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    garant <= 3'b000;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
